// File: rtl/layer_train_ctrl_pkg.sv
// Shared types for the layer training sequencer.
// zero2one_t / frac_t mirror the unsigned 0..1 and fractional encodings
// used by the neuron_learn layer (8-bit, MSB weight 0.5).
package layer_train_ctrl_pkg;

  localparam int Z2O_W  = 8;
  localparam int FRAC_W = 8;

  typedef logic [Z2O_W-1:0]  zero2one_t;
  typedef logic [FRAC_W-1:0] frac_t;

  // Width of the epoch and sample-index counters.
  localparam int TRAIN_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETTLE,
    ST_LEARN,
    ST_EMIT
  } train_state_t;

  // True when a zero2one_t value is at or above 0.5.
  function automatic logic z2o_upper_half(input zero2one_t v);
    return v[Z2O_W-1];
  endfunction

endpackage

// File: rtl/layer_mismatch_detect.sv
// layer_mismatch_detect: flags a sample whose layer output and target fall
// on opposite sides of 0.5 for any neuron (MSB compare, OR-reduced).
module layer_mismatch_detect
  import layer_train_ctrl_pkg::*;
#(
  parameter int N_OUT = 15
) (
  input  zero2one_t [N_OUT-1:0] result,
  input  zero2one_t [N_OUT-1:0] expected,
  output logic                  mismatch
);

  // OR-reduce the per-neuron half-range disagreement.
  always_comb begin
    mismatch = 1'b0;
    for (int j = 0; j < N_OUT; j++) begin
      mismatch = mismatch | (z2o_upper_half(result[j]) ^ z2o_upper_half(expected[j]));
    end
  end

endmodule

// File: rtl/layer_train_ctrl.sv
// layer_train_ctrl: drives one fully-connected learning layer through
// training (EPOCHS epochs with a learn strobe per sample) or inference
// (one epoch, no learn) runs, fed by a valid/ready sample stream.
// Optional feature macro: LAYER_TRAIN_CTRL_ERRCNT_EN adds a 16-bit
// saturating err_count of samples whose output and target disagree.
//
// state  | meaning
// IDLE   | waiting for start; counters hold the previous run's final values
// WAIT   | sample_ready high, waiting for sample_valid
// SETTLE | sample presented (layer_valid), counting SETTLE cycles
// LEARN  | single learn strobe, train mode only
// EMIT   | result_valid pulse, counter advance, done on the last sample
module layer_train_ctrl
  import layer_train_ctrl_pkg::*;
#(
  parameter int N_IN      = 16,
  parameter int N_OUT     = 15,
  parameter int SETTLE    = 2,
  parameter int EPOCH_LEN = 8,
  parameter int EPOCHS    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   train,
  output logic                   busy,
  output logic                   done,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  zero2one_t [N_IN-1:0]   sample_in,
  input  zero2one_t [N_OUT-1:0]  sample_expected,
  output logic                   layer_valid,
  output logic                   layer_learn,
  output zero2one_t [N_IN-1:0]   layer_in,
  output zero2one_t [N_OUT-1:0]  layer_expected_out,
  input  zero2one_t [N_OUT-1:0]  layer_out,
  output logic                   result_valid,
  output zero2one_t [N_OUT-1:0]  result_out,
  output logic [TRAIN_CNT_W-1:0] epoch,
  output logic [TRAIN_CNT_W-1:0] sample_idx
`ifdef LAYER_TRAIN_CTRL_ERRCNT_EN
  ,
  output logic [15:0]            err_count
`endif
);

  localparam logic [3:0]             SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [TRAIN_CNT_W-1:0] LAST_IDX    = TRAIN_CNT_W'(EPOCH_LEN - 1);
  localparam logic [TRAIN_CNT_W-1:0] LAST_EPOCH  = TRAIN_CNT_W'(EPOCHS - 1);

  train_state_t state;
  train_state_t state_nxt;

  logic       mode;
  logic [3:0] settle_cnt;

  logic start_acc;
  logic sample_acc;
  logic settle_inc;
  logic capture;
  logic advance;
  logic epoch_end;
  logic last_epoch;

  // Last sample of the epoch, and whether the current epoch closes the run.
  assign epoch_end  = (sample_idx == LAST_IDX);
  assign last_epoch = mode ? (epoch == LAST_EPOCH) : (epoch == '0);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus Moore outputs and datapath strobes.
  always_comb begin
    state_nxt    = state;
    busy         = (state != ST_IDLE);
    done         = 1'b0;
    sample_ready = 1'b0;
    layer_valid  = 1'b0;
    layer_learn  = 1'b0;
    result_valid = 1'b0;
    start_acc    = 1'b0;
    sample_acc   = 1'b0;
    settle_inc   = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          sample_acc = 1'b1;
          state_nxt  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        layer_valid = 1'b1;
        if (settle_cnt == SETTLE_LAST) begin
          capture   = 1'b1;
          state_nxt = mode ? ST_LEARN : ST_EMIT;
        end else begin
          settle_inc = 1'b1;
        end
      end
      ST_LEARN: begin
        layer_valid = 1'b1;
        layer_learn = 1'b1;
        state_nxt   = ST_EMIT;
      end
      ST_EMIT: begin
        result_valid = 1'b1;
        if (epoch_end && last_epoch) begin
          // Counters hold so the final position stays visible after done.
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          advance   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run mode and epoch/sample position counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode       <= 1'b0;
      epoch      <= '0;
      sample_idx <= '0;
    end else if (start_acc) begin
      mode       <= train;
      epoch      <= '0;
      sample_idx <= '0;
    end else if (advance) begin
      if (epoch_end) begin
        sample_idx <= '0;
        epoch      <= epoch + 1'b1;
      end else begin
        sample_idx <= sample_idx + 1'b1;
      end
    end
  end

  // Settle timer, restarted for every accepted sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (sample_acc) begin
      settle_cnt <= '0;
    end else if (settle_inc) begin
      settle_cnt <= settle_cnt + 4'd1;
    end
  end

  // Sample registers: held stable from acceptance until the next sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      layer_in           <= '0;
      layer_expected_out <= '0;
    end else if (sample_acc) begin
      layer_in           <= sample_in;
      layer_expected_out <= sample_expected;
    end
  end

  // Layer result captured on the edge that leaves SETTLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_out <= '0;
    end else if (capture) begin
      result_out <= layer_out;
    end
  end

`ifdef LAYER_TRAIN_CTRL_ERRCNT_EN
  logic mismatch;

  layer_mismatch_detect #(
    .N_OUT(N_OUT)
  ) u_mismatch (
    .result  (result_out),
    .expected(layer_expected_out),
    .mismatch(mismatch)
  );

  // Count disagreeing samples once per EMIT, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= '0;
    end else if (start_acc) begin
      err_count <= '0;
    end else if (result_valid && mismatch && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
